// File: rtl/dmem_wb_bridge_pkg.sv
// Shared LC-3b types used by the data-memory Wishbone bridge.
// Word/mask typedefs, bridge FSM states and a write-lane helper.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP,
    DONE
  } lc3b_wb_state;

  // Byte stores carry the byte in [7:0]; replicate it to both lanes.
  function automatic lc3b_word wb_lane_data(
    input lc3b_word      wdata,
    input lc3b_mem_wmask sel
  );
    if (sel == 2'b11) return wdata;
    return {wdata[7:0], wdata[7:0]};
  endfunction

endpackage

// File: rtl/dmem_wb_bridge_timeout.sv
// Ack timeout counter for the data-memory bridge.
// tc_o flags the last allowed BUS cycle; disabled when TIMEOUT_CYCLES is 0.
module wb_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_WIDTH      = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [CNT_WIDTH-1:0] LAST =
    CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (TIMEOUT_CYCLES != 0) && (cnt_q == LAST);

endmodule

// File: rtl/register.sv
// Generic loadable register with asynchronous active-high reset.
// Clears to zero on reset, captures in_i when load_i is high.
module register #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] out_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= in_i;
    end
  end

  assign out_o = data_q;

endmodule

// File: rtl/dmem_wb_bridge.sv
// MEM-stage to Wishbone data-memory bridge: one single-beat transfer
// per pipeline request, one-cycle response, optional ack timeout.
module dmem_wb_bridge
  import lc3b_types::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_WIDTH      = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_ex_mem,
  input  logic          dmem_action_cyc,
  input  logic          dmem_action_stb,
  input  logic          dmem_write,
  input  lc3b_mem_wmask dmem_byte_enable,
  input  lc3b_word      dmem_address,
  input  lc3b_word      dmem_wdata,
  output logic          dmem_resp,
  output logic          dmem_err,
  output lc3b_word      dmem_rdata,
  output logic          wb_cyc,
  output logic          wb_stb,
  output logic          wb_we,
  output logic [1:0]    wb_sel,
  output logic [14:0]   wb_adr,
  output lc3b_word      wb_dat_o,
  input  lc3b_word      wb_dat_i,
  input  logic          wb_ack
);

  lc3b_wb_state state_q;
  logic armed_q;
  logic flush_q;
  logic cyc_q;
  logic stb_q;
  logic resp_q;
  logic err_q;

  logic req;
  logic in_bus;
  logic tc;
  logic bus_end;
  logic flush_now;
  logic req_load;
  logic rd_load;
  logic [33:0] req_d;
  logic [33:0] req_q;
  lc3b_word rd_d;

  assign req = dmem_action_cyc & dmem_action_stb & armed_q;
  assign in_bus = (state_q == BUS);
  assign bus_end = wb_ack | tc;
  assign flush_now = flush_q | ~dmem_action_cyc;
  assign req_load = (state_q == IDLE) & req;

  assign req_d = {dmem_write,
                  dmem_byte_enable,
                  dmem_address[15:1],
                  wb_lane_data(dmem_wdata, dmem_byte_enable)};

  register #(.WIDTH(34)) u_req_reg (
    .clk    (clk),
    .rst    (rst),
    .load_i (req_load),
    .in_i   (req_d),
    .out_o  (req_q)
  );

  // Ack has priority over a coincident timeout; stores keep old data.
  assign rd_load = in_bus & ~flush_now &
                   ((wb_ack & ~req_q[33]) | (~wb_ack & tc));
  assign rd_d = wb_ack ? wb_dat_i : 16'h0000;

  register #(.WIDTH(16)) u_rd_reg (
    .clk    (clk),
    .rst    (rst),
    .load_i (rd_load),
    .in_i   (rd_d),
    .out_o  (dmem_rdata)
  );

  wb_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_WIDTH      (CNT_WIDTH)
  ) u_tmo (
    .clk   (clk),
    .rst   (rst),
    .clr_i (~in_bus),
    .en_i  (in_bus),
    .tc_o  (tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      armed_q <= 1'b1;
      flush_q <= 1'b0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      resp_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      resp_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req) begin
            armed_q <= 1'b0;
            flush_q <= 1'b0;
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
            state_q <= BUS;
          end
        end
        BUS: begin
          if (!dmem_action_cyc) flush_q <= 1'b1;
          if (bus_end) begin
            cyc_q <= 1'b0;
            stb_q <= 1'b0;
            if (flush_now) begin
              armed_q <= 1'b1;
              state_q <= IDLE;
            end else begin
              resp_q  <= 1'b1;
              err_q   <= ~wb_ack;
              state_q <= RESP;
            end
          end
        end
        RESP: begin
          if (load_ex_mem) begin
            armed_q <= 1'b1;
            state_q <= IDLE;
          end else begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (load_ex_mem) begin
            armed_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dmem_resp = resp_q;
  assign dmem_err  = err_q;
  assign wb_cyc    = cyc_q;
  assign wb_stb    = stb_q;
  assign wb_we     = req_q[33];
  assign wb_sel    = req_q[32:31];
  assign wb_adr    = req_q[30:16];
  assign wb_dat_o  = req_q[15:0];

endmodule

// File: tb/tb_dmem_wb_bridge.sv
// Directed self-checking bench for dmem_wb_bridge.
// Runs with an 8-cycle ack timeout.
module tb_dmem_wb_bridge;

  logic        clk;
  logic        rst;
  logic        load_ex_mem;
  logic        dmem_action_cyc;
  logic        dmem_action_stb;
  logic        dmem_write;
  logic [1:0]  dmem_byte_enable;
  logic [15:0] dmem_address;
  logic [15:0] dmem_wdata;
  logic        dmem_resp;
  logic        dmem_err;
  logic [15:0] dmem_rdata;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [1:0]  wb_sel;
  logic [14:0] wb_adr;
  logic [15:0] wb_dat_o;
  logic [15:0] wb_dat_i;
  logic        wb_ack;

  int checks;
  int errors;
  int xfers;
  logic cyc_prev;

  dmem_wb_bridge #(
    .TIMEOUT_CYCLES (8),
    .CNT_WIDTH      (7)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .load_ex_mem      (load_ex_mem),
    .dmem_action_cyc  (dmem_action_cyc),
    .dmem_action_stb  (dmem_action_stb),
    .dmem_write       (dmem_write),
    .dmem_byte_enable (dmem_byte_enable),
    .dmem_address     (dmem_address),
    .dmem_wdata       (dmem_wdata),
    .dmem_resp        (dmem_resp),
    .dmem_err         (dmem_err),
    .dmem_rdata       (dmem_rdata),
    .wb_cyc           (wb_cyc),
    .wb_stb           (wb_stb),
    .wb_we            (wb_we),
    .wb_sel           (wb_sel),
    .wb_adr           (wb_adr),
    .wb_dat_o         (wb_dat_o),
    .wb_dat_i         (wb_dat_i),
    .wb_ack           (wb_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_prev <= 1'b0;
    end else begin
      cyc_prev <= wb_cyc;
      if (wb_cyc && !cyc_prev) xfers <= xfers + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic we, input logic [1:0] be,
                     input logic [15:0] adr, input logic [15:0] wd);
    dmem_action_cyc  = 1'b1;
    dmem_action_stb  = 1'b1;
    dmem_write       = we;
    dmem_byte_enable = be;
    dmem_address     = adr;
    dmem_wdata       = wd;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    xfers = 0;
    rst = 1'b1;
    load_ex_mem = 1'b0;
    dmem_action_cyc = 1'b0;
    dmem_action_stb = 1'b0;
    dmem_write = 1'b0;
    dmem_byte_enable = 2'b00;
    dmem_address = 16'h0000;
    dmem_wdata = 16'h0000;
    wb_dat_i = 16'h0000;
    wb_ack = 1'b0;
    tick();
    tick();
    chk("rst_cyc", {15'd0, wb_cyc}, 16'h0);
    chk("rst_stb", {15'd0, wb_stb}, 16'h0);
    chk("rst_resp", {15'd0, dmem_resp}, 16'h0);
    chk("rst_rdata", dmem_rdata, 16'h0000);
    chk("rst_adr", {1'b0, wb_adr}, 16'h0000);
    rst = 1'b0;
    tick();

    // word load, zero-wait ack
    req(1'b0, 2'b11, 16'h3006, 16'h0000);
    tick();
    chk("t1_stb", {15'd0, wb_stb}, 16'h1);
    chk("t1_cyc", {15'd0, wb_cyc}, 16'h1);
    chk("t1_adr", {1'b0, wb_adr}, 16'h1803);
    chk("t1_sel", {14'd0, wb_sel}, 16'h3);
    chk("t1_we", {15'd0, wb_we}, 16'h0);
    chk("t1_resp_early", {15'd0, dmem_resp}, 16'h0);
    wb_ack = 1'b1;
    wb_dat_i = 16'hBEEF;
    tick();
    chk("t1_resp", {15'd0, dmem_resp}, 16'h1);
    chk("t1_err", {15'd0, dmem_err}, 16'h0);
    chk("t1_rdata", dmem_rdata, 16'hBEEF);
    chk("t1_stb_drop", {15'd0, wb_stb}, 16'h0);
    wb_ack = 1'b0;
    wb_dat_i = 16'h0000;
    dmem_action_cyc = 1'b0;
    dmem_action_stb = 1'b0;
    tick();
    chk("t1_resp_pulse", {15'd0, dmem_resp}, 16'h0);
    chk("t1_rdata_hold", dmem_rdata, 16'hBEEF);
    load_ex_mem = 1'b1;
    tick();
    load_ex_mem = 1'b0;

    // wack ignored in IDLE
    wb_ack = 1'b1;
    tick();
    chk("idle_ack_resp", {15'd0, dmem_resp}, 16'h0);
    chk("idle_ack_stb", {15'd0, wb_stb}, 16'h0);
    wb_ack = 1'b0;

    // byte store, 3 wait states
    req(1'b1, 2'b10, 16'h2001, 16'h00A5);
    tick();
    chk("t2_dat", wb_dat_o, 16'hA5A5);
    chk("t2_sel", {14'd0, wb_sel}, 16'h2);
    chk("t2_we", {15'd0, wb_we}, 16'h1);
    chk("t2_adr", {1'b0, wb_adr}, 16'h1000);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_wait_stb", {15'd0, wb_stb}, 16'h1);
      chk("t2_wait_resp", {15'd0, dmem_resp}, 16'h0);
    end
    wb_ack = 1'b1;
    wb_dat_i = 16'h1234;
    tick();
    chk("t2_resp", {15'd0, dmem_resp}, 16'h1);
    chk("t2_err", {15'd0, dmem_err}, 16'h0);
    chk("t2_rdata_kept", dmem_rdata, 16'hBEEF);
    wb_ack = 1'b0;
    dmem_action_cyc = 1'b0;
    dmem_action_stb = 1'b0;
    load_ex_mem = 1'b1;
    tick();
    load_ex_mem = 1'b0;
    chk("t2_xfers", xfers[15:0], 16'd2);

    // back-to-back loads, stb held
    req(1'b0, 2'b11, 16'h0010, 16'h0000);
    tick();
    wb_ack = 1'b1;
    wb_dat_i = 16'h1111;
    tick();
    chk("t3a_resp", {15'd0, dmem_resp}, 16'h1);
    chk("t3a_rdata", dmem_rdata, 16'h1111);
    wb_ack = 1'b0;
    load_ex_mem = 1'b1;
    dmem_address = 16'h0020;
    tick();
    load_ex_mem = 1'b0;
    chk("t3_idle_stb", {15'd0, wb_stb}, 16'h0);
    tick();
    chk("t3b_stb", {15'd0, wb_stb}, 16'h1);
    chk("t3b_adr", {1'b0, wb_adr}, 16'h0010);
    wb_ack = 1'b1;
    wb_dat_i = 16'h2222;
    tick();
    chk("t3b_resp", {15'd0, dmem_resp}, 16'h1);
    chk("t3b_rdata", dmem_rdata, 16'h2222);
    wb_ack = 1'b0;
    chk("t3_xfers", xfers[15:0], 16'd4);

    // delayed load_ex_mem: DONE holds off
    dmem_address = 16'h0030;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_done_stb", {15'd0, wb_stb}, 16'h0);
      chk("t4_done_resp", {15'd0, dmem_resp}, 16'h0);
    end
    chk("t4_xfers_held", xfers[15:0], 16'd4);
    load_ex_mem = 1'b1;
    tick();
    load_ex_mem = 1'b0;
    chk("t4_idle_stb", {15'd0, wb_stb}, 16'h0);
    tick();
    chk("t4_stb", {15'd0, wb_stb}, 16'h1);
    chk("t4_adr", {1'b0, wb_adr}, 16'h0018);
    wb_ack = 1'b1;
    wb_dat_i = 16'h3333;
    tick();
    chk("t4_resp", {15'd0, dmem_resp}, 16'h1);
    chk("t4_rdata", dmem_rdata, 16'h3333);
    wb_ack = 1'b0;
    dmem_action_cyc = 1'b0;
    dmem_action_stb = 1'b0;
    load_ex_mem = 1'b1;
    tick();
    load_ex_mem = 1'b0;
    chk("t4_xfers", xfers[15:0], 16'd5);

    // timeout: no ack for 8 cycles
    req(1'b0, 2'b11, 16'h0040, 16'h0000);
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("t5_stb", {15'd0, wb_stb}, 16'h1);
      chk("t5_resp", {15'd0, dmem_resp}, 16'h0);
      tick();
    end
    chk("t5_resp_to", {15'd0, dmem_resp}, 16'h1);
    chk("t5_err", {15'd0, dmem_err}, 16'h1);
    chk("t5_rdata", dmem_rdata, 16'h0000);
    chk("t5_stb_drop", {15'd0, wb_stb}, 16'h0);
    dmem_action_cyc = 1'b0;
    dmem_action_stb = 1'b0;
    load_ex_mem = 1'b1;
    tick();
    load_ex_mem = 1'b0;

    // ack coincident with timeout expiry
    req(1'b0, 2'b11, 16'h0044, 16'h0000);
    tick();
    for (int i = 0; i < 7; i++) tick();
    chk("t6_stb_last", {15'd0, wb_stb}, 16'h1);
    wb_ack = 1'b1;
    wb_dat_i = 16'h6666;
    tick();
    chk("t6_resp", {15'd0, dmem_resp}, 16'h1);
    chk("t6_err", {15'd0, dmem_err}, 16'h0);
    chk("t6_rdata", dmem_rdata, 16'h6666);
    wb_ack = 1'b0;
    dmem_action_cyc = 1'b0;
    dmem_action_stb = 1'b0;
    load_ex_mem = 1'b1;
    tick();
    load_ex_mem = 1'b0;

    // flush while in BUS
    req(1'b0, 2'b11, 16'h0070, 16'h0000);
    tick();
    dmem_action_cyc = 1'b0;
    dmem_action_stb = 1'b0;
    tick();
    chk("t7_stb_hold", {15'd0, wb_stb}, 16'h1);
    wb_ack = 1'b1;
    wb_dat_i = 16'h7777;
    tick();
    chk("t7_no_resp", {15'd0, dmem_resp}, 16'h0);
    chk("t7_rdata", dmem_rdata, 16'h6666);
    chk("t7_stb_drop", {15'd0, wb_stb}, 16'h0);
    wb_ack = 1'b0;
    req(1'b0, 2'b11, 16'h0080, 16'h0000);
    tick();
    chk("t7_rearm_stb", {15'd0, wb_stb}, 16'h1);
    chk("t7_rearm_adr", {1'b0, wb_adr}, 16'h0040);
    wb_ack = 1'b1;
    wb_dat_i = 16'h5555;
    tick();
    chk("t7_resp", {15'd0, dmem_resp}, 16'h1);
    chk("t7_rdata_new", dmem_rdata, 16'h5555);
    wb_ack = 1'b0;
    dmem_action_cyc = 1'b0;
    dmem_action_stb = 1'b0;
    load_ex_mem = 1'b1;
    tick();
    load_ex_mem = 1'b0;

    // reset mid-BUS
    req(1'b0, 2'b11, 16'h0050, 16'h0000);
    tick();
    chk("t8_stb", {15'd0, wb_stb}, 16'h1);
    #1 rst = 1'b1;
    #1;
    chk("t8_cyc_rst", {15'd0, wb_cyc}, 16'h0);
    chk("t8_stb_rst", {15'd0, wb_stb}, 16'h0);
    chk("t8_rdata_rst", dmem_rdata, 16'h0000);
    dmem_address = 16'h0060;
    tick();
    rst = 1'b0;
    tick();
    chk("t8_fresh_stb", {15'd0, wb_stb}, 16'h1);
    chk("t8_fresh_adr", {1'b0, wb_adr}, 16'h0030);
    wb_ack = 1'b1;
    wb_dat_i = 16'h4444;
    tick();
    chk("t8_resp", {15'd0, dmem_resp}, 16'h1);
    chk("t8_err", {15'd0, dmem_err}, 16'h0);
    chk("t8_rdata", dmem_rdata, 16'h4444);
    wb_ack = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_wb_bridge.md
Name: dmem_wb_bridge

Overview:
- Sits directly downstream of the MEM-stage stall/request logic, between the pipeline's data-memory request signals and the Wishbone-style data memory port.
- Registers each pipeline request, runs one single-beat bus transfer, and returns a one-cycle dmem_resp with held read data. The MEM stage uses this response to release its stall.
- Re-arms only when the pipeline advances, so back-to-back memory instructions produce distinct transfers.
- Bounds every transfer with an optional ack timeout.

Parameters:
- TIMEOUT_CYCLES, 64, BUS-state cycles without wb_ack before forced error completion; 0 disables the timeout.
- CNT_WIDTH, 7, timeout counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- load_ex_mem  in  1  EX/MEM pipeline register load; the pipeline advances at this edge
- dmem_action_cyc  in  1  request cycle from MEM stage
- dmem_action_stb  in  1  request strobe from MEM stage
- dmem_write  in  1  1 = store
- dmem_byte_enable  in  2  lc3b_mem_wmask; 11 word, 01 low byte, 10 high byte
- dmem_address  in  16  byte address
- dmem_wdata  in  16  store data; byte stores carry the byte in [7:0]
- dmem_resp  out  1  transfer complete, one-cycle pulse
- dmem_err  out  1  valid with dmem_resp; 1 = timeout
- dmem_rdata  out  16  load data, held until the next completion
- wb_cyc  out  1  bus cycle
- wb_stb  out  1  bus strobe
- wb_we  out  1  bus write
- wb_sel  out  2  bus byte select
- wb_adr  out  15  word address (dmem_address[15:1])
- wb_dat_o  out  16  bus write data
- wb_dat_i  in  16  bus read data
- wb_ack  in  1  bus acknowledge

Behaviour:
- Reset (asynchronous, immediate): state IDLE, armed=1, all outputs 0, dmem_rdata=0, timeout counter 0. Reset mid-transfer drops wb_cyc and wb_stb at once.
- Request: req = dmem_action_cyc & dmem_action_stb & armed.
- IDLE:
  - On req, latch address, we, sel and wdata into internal registers, clear armed, go to BUS.
  - All wb_* outputs are registered, so wb_cyc and wb_stb rise in the cycle after the request is sampled.
  - wb_ack in IDLE is ignored.
- BUS:
  - wb_cyc = wb_stb = 1; wb_we, wb_sel, wb_adr, wb_dat_o are stable from the latched registers.
  - On wb_ack: capture wb_dat_i into dmem_rdata (loads only; stores leave it unchanged), drop wb_cyc/wb_stb next cycle, go to RESP with err=0.
  - The timeout counter increments each BUS cycle. If it equals TIMEOUT_CYCLES-1 with no ack: drop the bus, dmem_rdata=0, go to RESP with err=1.
  - If dmem_action_cyc falls while in BUS (flush): the bus transfer still completes (ack or timeout), the result is discarded, no dmem_resp is issued, next state is IDLE, armed=1.
- RESP:
  - dmem_resp=1 for exactly one cycle; dmem_err is valid.
  - If load_ex_mem=1 in this cycle: set armed, go to IDLE. Otherwise go to DONE.
- DONE:
  - dmem_resp=0; stb may remain high, but no new transfer starts.
  - On load_ex_mem: set armed, go to IDLE.
- Minimum latency: request sampled at edge N, wb_stb high in cycle N+1, zero-wait ack sampled at edge N+1, dmem_resp high in cycle N+2.
- Write data:
  - sel=11: wb_dat_o = wdata.
  - sel=01 or 10: wb_dat_o = {wdata[7:0], wdata[7:0]}, byte replicated into both lanes.
- Reads always return the full word; byte extraction is downstream.
- Simultaneous wb_ack and timeout expiry: the ack wins, err=0.
- The request inputs are sampled only in IDLE.

Decomposition:
- Shared package lc3b_types: lc3b_word, lc3b_mem_wmask, and a new enum lc3b_wb_state {IDLE, BUS, RESP, DONE}.
- One sub-module, wb_timeout_counter: clear, enable, terminal-count output; parameterised by TIMEOUT_CYCLES and CNT_WIDTH.
- The latched request and read data use the existing register module.

Test Plan:
- Word load at 0x3006, slave acks in the first cycle with 0xBEEF -> wb_adr=0x1803, wb_sel=11, wb_we=0; dmem_resp pulses in cycle N+2; dmem_rdata=0xBEEF held afterwards.
- Byte store 0x00A5 to 0x2001 (sel=10), 3 wait states -> wb_dat_o=0xA5A5, wb_sel=10, wb_we=1; dmem_resp one cycle after the ack.
- Two back-to-back loads with stb held high and load_ex_mem pulsed in the RESP cycle -> exactly two bus transfers; no transfer occurs while in DONE.
- Resp arrives but load_ex_mem is delayed 3 cycles -> state DONE, no second transfer; the new transfer starts after the load_ex_mem edge.
- Slave never acks, TIMEOUT_CYCLES=8 -> wb_stb high for 8 cycles, then dmem_resp=1, dmem_err=1, dmem_rdata=0x0000.
- rst asserted mid-BUS -> wb_cyc/wb_stb low immediately; after release, state IDLE and armed=1, and a fresh request completes normally.
